// File: rtl/atc_pkg.sv
// Shared types and constants for the runway allocation path and the reply builder.
package atc_pkg;

    localparam int PLANE_ID_W = 4;
    localparam int REC_CNT_W  = 16;

    typedef logic [PLANE_ID_W-1:0] plane_id_t;

    typedef struct packed {
        logic                 active;
        plane_id_t            owner;
        logic [REC_CNT_W-1:0] count;
    } runway_rec_t;

    // Reply opcodes: grant -> CLEAR, release error -> HOLD, timeout -> DIVERT
    localparam logic [2:0] OP_CLEAR  = 3'b011;
    localparam logic [2:0] OP_HOLD   = 3'b100;
    localparam logic [2:0] OP_DIVERT = 3'b110;

    function automatic int unsigned popcount16(input logic [15:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/runway_slot.sv
// One runway: occupancy flag, owning plane ID and occupancy-age counter.
// Lock and release never target the same slot on one edge; release beats timeout.
module runway_slot
    import atc_pkg::*;
#(
    parameter int ID_WIDTH = PLANE_ID_W,
    parameter int TIMEOUT  = 1024,
    parameter int CW       = 11
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_lock,
    input  logic [ID_WIDTH-1:0] i_lock_id,
    input  logic                i_rel_sel,
    input  logic [ID_WIDTH-1:0] i_rel_id,
    output logic                o_active,
    output logic                o_rel_ok,
    output logic                o_expire
);

    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef struct packed {
        logic                active;
        logic [ID_WIDTH-1:0] owner;
        logic [CW-1:0]       count;
    } slot_rec_t;

    slot_rec_t r_slot;

    assign o_active = r_slot.active;
    assign o_rel_ok = i_rel_sel && r_slot.active && (r_slot.owner == i_rel_id);
    assign o_expire = (TIMEOUT > 0) && r_slot.active && (r_slot.count == LAST) && !o_rel_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_slot <= '0;
        end else if (i_lock) begin
            r_slot.active <= 1'b1;
            r_slot.owner  <= i_lock_id;
            r_slot.count  <= '0;
        end else if (o_rel_ok || o_expire) begin
            r_slot.active <= 1'b0;
            r_slot.count  <= '0;
        end else if (r_slot.active && (TIMEOUT > 0)) begin
            r_slot.count <= r_slot.count + 1'b1;
        end
    end

endmodule

// File: rtl/runway_allocator.sv
// Grants the lowest-index eligible free runway, checks releases against owner, auto-releases on timeout.
// Grant/error/timeout pulses one cycle after the edge; req_ready drops while no eligible runway is free.
module runway_allocator
    import atc_pkg::*;
#(
    parameter  int NUM_RUNWAYS       = 4,
    parameter  int ID_WIDTH          = PLANE_ID_W,
    parameter  int TIMEOUT           = 1024,
    parameter  int RESERVE_EMERGENCY = 0,
    localparam int RID_W             = (NUM_RUNWAYS > 1) ? $clog2(NUM_RUNWAYS) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ID_WIDTH-1:0]    req_id,
    input  logic                   req_emergency,
    output logic                   grant_valid,
    output logic [RID_W-1:0]       grant_runway,
    output logic [ID_WIDTH-1:0]    grant_id,
    input  logic                   rel_valid,
    input  logic [RID_W-1:0]       rel_runway,
    input  logic [ID_WIDTH-1:0]    rel_id,
    output logic                   rel_error,
    output logic [NUM_RUNWAYS-1:0] timeout_mask,
    output logic [NUM_RUNWAYS-1:0] runway_active,
    output logic [RID_W:0]         busy_count
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [NUM_RUNWAYS-1:0] w_active;
    logic [NUM_RUNWAYS-1:0] w_elig;
    logic [NUM_RUNWAYS-1:0] w_lock;
    logic [NUM_RUNWAYS-1:0] w_rel_ok;
    logic [NUM_RUNWAYS-1:0] w_expire;
    logic [NUM_RUNWAYS-1:0] w_next_active;
    logic [RID_W-1:0]       w_pick;
    logic                   w_accept;
    logic                   w_rel_err;

    logic                   r_grant_vld;
    logic [RID_W-1:0]       r_grant_runway;
    logic [ID_WIDTH-1:0]    r_grant_id;
    logic                   r_rel_error;
    logic [NUM_RUNWAYS-1:0] r_timeout_mask;
    logic [RID_W:0]         r_busy;

    genvar g;
    generate
        for (g = 0; g < NUM_RUNWAYS; g++) begin : g_slot
            // Runway 0 may be held back for emergencies only
            assign w_elig[g] = !w_active[g] &&
                               !((RESERVE_EMERGENCY != 0) && (g == 0) && !req_emergency);
            assign w_lock[g] = w_accept && (w_pick == RID_W'(g));

            runway_slot #(
                .ID_WIDTH (ID_WIDTH),
                .TIMEOUT  (TIMEOUT),
                .CW       (CW)
            ) u_slot (
                .clock     (clock),
                .reset     (reset),
                .i_lock    (w_lock[g]),
                .i_lock_id (req_id),
                .i_rel_sel (rel_valid && (rel_runway == RID_W'(g))),
                .i_rel_id  (rel_id),
                .o_active  (w_active[g]),
                .o_rel_ok  (w_rel_ok[g]),
                .o_expire  (w_expire[g])
            );
        end
    endgenerate

    always_comb begin
        w_pick = '0;
        for (int i = NUM_RUNWAYS - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_pick = RID_W'(i);
            end
        end
    end

    assign req_ready     = |w_elig;
    assign w_accept      = req_valid && req_ready;
    // Out-of-range runway index matches no slot and so lands here as an error
    assign w_rel_err     = rel_valid && !(|w_rel_ok);
    assign w_next_active = (w_active | w_lock) & ~(w_rel_ok | w_expire);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_grant_vld    <= 1'b0;
            r_grant_runway <= '0;
            r_grant_id     <= '0;
            r_rel_error    <= 1'b0;
            r_timeout_mask <= '0;
            r_busy         <= '0;
        end else begin
            r_grant_vld    <= w_accept;
            r_rel_error    <= w_rel_err;
            r_timeout_mask <= w_expire;
            r_busy         <= (RID_W + 1)'(popcount16(16'(w_next_active)));
            if (w_accept) begin
                r_grant_runway <= w_pick;
                r_grant_id     <= req_id;
            end
        end
    end

    assign grant_valid   = r_grant_vld;
    assign grant_runway  = r_grant_runway;
    assign grant_id      = r_grant_id;
    assign rel_error     = r_rel_error;
    assign timeout_mask  = r_timeout_mask;
    assign runway_active = w_active;
    assign busy_count    = r_busy;

endmodule

// File: tb/tb_runway_allocator.sv
// Bench for runway_allocator: instance A (TIMEOUT=1024), instance B (TIMEOUT=8, runway 0 reserved).
module tb_runway_allocator;

    logic       clock;
    logic       rst          [2];
    logic       req_valid    [2];
    logic       req_ready    [2];
    logic [3:0] req_id       [2];
    logic       req_emg      [2];
    logic       grant_valid  [2];
    logic [1:0] grant_runway [2];
    logic [3:0] grant_id     [2];
    logic       rel_valid    [2];
    logic [1:0] rel_runway   [2];
    logic [3:0] rel_id       [2];
    logic       rel_error    [2];
    logic [3:0] timeout_mask [2];
    logic [3:0] runway_active[2];
    logic [2:0] busy_count   [2];

    int checks = 0;
    int errors = 0;

    runway_allocator #(.NUM_RUNWAYS(4), .ID_WIDTH(4), .TIMEOUT(1024), .RESERVE_EMERGENCY(0)) dut_a (
        .clock(clock), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_id(req_id[0]), .req_emergency(req_emg[0]), .grant_valid(grant_valid[0]),
        .grant_runway(grant_runway[0]), .grant_id(grant_id[0]), .rel_valid(rel_valid[0]),
        .rel_runway(rel_runway[0]), .rel_id(rel_id[0]), .rel_error(rel_error[0]),
        .timeout_mask(timeout_mask[0]), .runway_active(runway_active[0]), .busy_count(busy_count[0]));

    runway_allocator #(.NUM_RUNWAYS(4), .ID_WIDTH(4), .TIMEOUT(8), .RESERVE_EMERGENCY(1)) dut_b (
        .clock(clock), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_id(req_id[1]), .req_emergency(req_emg[1]), .grant_valid(grant_valid[1]),
        .grant_runway(grant_runway[1]), .grant_id(grant_id[1]), .rel_valid(rel_valid[1]),
        .rel_runway(rel_runway[1]), .rel_id(rel_id[1]), .rel_error(rel_error[1]),
        .timeout_mask(timeout_mask[1]), .runway_active(runway_active[1]), .busy_count(busy_count[1]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: occupancy table, owners, and cycles spent occupied.
    int m_timeout [2] = '{1024, 8};
    bit m_reserve [2] = '{1'b0, 1'b1};
    bit m_started [2] = '{1'b0, 1'b0};
    bit m_act     [2][4];
    int m_own     [2][4];
    int m_age     [2][4];
    bit e_gv  [2];
    int e_gr  [2];
    int e_gi  [2];
    bit e_re  [2];
    int e_tm  [2];

    function automatic bit m_elig(input int d, input int i);
        return !m_act[d][i] && !(m_reserve[d] && i == 0 && !req_emg[d]);
    endfunction

    function automatic bit m_ready(input int d);
        bit r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) r |= m_elig(d, i);
        return r;
    endfunction

    function automatic int m_busy(input int d);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) n += int'(m_act[d][i]);
        return n;
    endfunction

    function automatic int m_vec(input int d);
        int v;
        v = 0;
        for (int i = 0; i < 4; i++) if (m_act[d][i]) v += (1 << i);
        return v;
    endfunction

    task automatic model_step(input int d);
        bit accept, rel_ok;
        int k, r;
        if (rst[d]) begin
            m_started[d] = 1'b1;
            for (int i = 0; i < 4; i++) begin
                m_act[d][i] = 1'b0; m_own[d][i] = 0; m_age[d][i] = 0;
            end
            e_gv[d] = 1'b0; e_gr[d] = 0; e_gi[d] = 0; e_re[d] = 1'b0; e_tm[d] = 0;
            return;
        end
        accept = req_valid[d] && m_ready(d);
        k = -1;
        for (int i = 3; i >= 0; i--) if (m_elig(d, i)) k = i;
        r = int'(rel_runway[d]);
        rel_ok = rel_valid[d] && m_act[d][r] && (m_own[d][r] == int'(rel_id[d]));
        e_re[d] = rel_valid[d] && !rel_ok;
        e_tm[d] = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_act[d][i]) begin
                if (rel_ok && r == i) begin
                    m_act[d][i] = 1'b0;
                end else begin
                    m_age[d][i]++;
                    if (m_timeout[d] > 0 && m_age[d][i] == m_timeout[d]) begin
                        m_act[d][i] = 1'b0;
                        e_tm[d] += (1 << i);
                    end
                end
            end
        end
        e_gv[d] = accept;
        if (accept) begin
            m_act[d][k] = 1'b1;
            m_own[d][k] = int'(req_id[d]);
            m_age[d][k] = 0;
            e_gr[d] = k;
            e_gi[d] = int'(req_id[d]);
        end
    endtask

    always @(posedge clock) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (m_started[d]) begin
                chk($sformatf("m%0d.req_ready", d),     32'(req_ready[d]),     32'(m_ready(d)));
                chk($sformatf("m%0d.grant_valid", d),   32'(grant_valid[d]),   32'(e_gv[d]));
                chk($sformatf("m%0d.grant_runway", d),  32'(grant_runway[d]),  e_gr[d]);
                chk($sformatf("m%0d.grant_id", d),      32'(grant_id[d]),      e_gi[d]);
                chk($sformatf("m%0d.rel_error", d),     32'(rel_error[d]),     32'(e_re[d]));
                chk($sformatf("m%0d.timeout_mask", d),  32'(timeout_mask[d]),  e_tm[d]);
                chk($sformatf("m%0d.runway_active", d), 32'(runway_active[d]), m_vec(d));
                chk($sformatf("m%0d.busy_count", d),    32'(busy_count[d]),    m_busy(d));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_id[d] = '0; req_emg[d] = 1'b0;
            rel_valid[d] = 1'b0; rel_runway[d] = '0; rel_id[d] = '0;
        end
        tick(); tick();
        rst[0] = 1'b0;
        chk("A.reset_active", 32'(runway_active[0]), 32'h0);
        chk("A.reset_busy",   32'(busy_count[0]),    32'h0);
        chk("A.reset_grant",  32'(grant_valid[0]),   32'h0);

        // First grant: runway 0, one cycle latency
        req_valid[0] = 1'b1; req_id[0] = 4'h3;
        #1 chk("A.ready_empty", 32'(req_ready[0]), 32'h1);
        tick();
        req_valid[0] = 1'b0;
        chk("A.g1_valid",  32'(grant_valid[0]),   32'h1);
        chk("A.g1_runway", 32'(grant_runway[0]),  32'h0);
        chk("A.g1_id",     32'(grant_id[0]),      32'h3);
        chk("A.g1_active", 32'(runway_active[0]), 32'h1);
        chk("A.g1_busy",   32'(busy_count[0]),    32'h1);
        tick();
        chk("A.g1_pulse_end", 32'(grant_valid[0]), 32'h0);
        chk("A.g1_id_hold",   32'(grant_id[0]),    32'h3);

        // Fill all four runways, then hold a fifth request
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            req_valid[0] = 1'b1; req_id[0] = 4'(i);
            tick();
            chk("A.fill_runway", 32'(grant_runway[0]), 32'(i - 1));
        end
        req_id[0] = 4'h5;
        #1 chk("A.full_ready", 32'(req_ready[0]), 32'h0);
        tick();
        chk("A.full_nogrant", 32'(grant_valid[0]), 32'h0);
        chk("A.full_busy",    32'(busy_count[0]),  32'h4);
        rel_valid[0] = 1'b1; rel_runway[0] = 2'd2; rel_id[0] = 4'h3;
        tick();
        rel_valid[0] = 1'b0;
        chk("A.rel2_active",  32'(runway_active[0]), 32'hB);
        chk("A.rel2_nogrant", 32'(grant_valid[0]),   32'h0);
        tick();
        req_valid[0] = 1'b0;
        chk("A.held_valid",  32'(grant_valid[0]),  32'h1);
        chk("A.held_runway", 32'(grant_runway[0]), 32'h2);
        chk("A.held_id",     32'(grant_id[0]),     32'h5);

        // Rejected releases: wrong owner, then a free runway
        rel_valid[0] = 1'b1; rel_runway[0] = 2'd1; rel_id[0] = 4'hA;
        tick();
        rel_valid[0] = 1'b0;
        chk("A.wrongid_err",    32'(rel_error[0]),     32'h1);
        chk("A.wrongid_active", 32'(runway_active[0]), 32'hF);
        tick();
        chk("A.err_pulse_end", 32'(rel_error[0]), 32'h0);
        rel_valid[0] = 1'b1; rel_runway[0] = 2'd2; rel_id[0] = 4'h5;
        tick();
        chk("A.rel_ok_active", 32'(runway_active[0]), 32'hB);
        tick();
        rel_valid[0] = 1'b0;
        chk("A.free_err",    32'(rel_error[0]),     32'h1);
        chk("A.free_active", 32'(runway_active[0]), 32'hB);

        // Reset while three runways busy and a grant pulse is out
        req_valid[0] = 1'b1; req_id[0] = 4'h7;
        tick();
        req_valid[0] = 1'b0; rst[0] = 1'b1;
        chk("A.pre_rst_grant", 32'(grant_valid[0]), 32'h1);
        tick();
        rst[0] = 1'b0;
        chk("A.rst_grant",  32'(grant_valid[0]),   32'h0);
        chk("A.rst_active", 32'(runway_active[0]), 32'h0);
        chk("A.rst_busy",   32'(busy_count[0]),    32'h0);
        chk("A.rst_gid",    32'(grant_id[0]),      32'h0);
        req_valid[0] = 1'b1; req_id[0] = 4'h6;
        tick();
        req_valid[0] = 1'b0;
        chk("A.post_rst_runway", 32'(grant_runway[0]), 32'h0);
        chk("A.post_rst_id",     32'(grant_id[0]),     32'h6);

        // Instance B: runway 0 reserved for emergencies
        rst[1] = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            req_valid[1] = 1'b1; req_id[1] = 4'(i); req_emg[1] = 1'b0;
            tick();
            chk("B.normal_runway", 32'(grant_runway[1]), 32'(i));
        end
        req_id[1] = 4'h4;
        #1 chk("B.reserved_ready", 32'(req_ready[1]), 32'h0);
        tick();
        chk("B.reserved_nogrant", 32'(grant_valid[1]), 32'h0);
        req_id[1] = 4'h9; req_emg[1] = 1'b1;
        #1 chk("B.emg_ready", 32'(req_ready[1]), 32'h1);
        tick();
        req_valid[1] = 1'b0; req_emg[1] = 1'b0;
        chk("B.emg_runway", 32'(grant_runway[1]), 32'h0);
        chk("B.emg_id",     32'(grant_id[1]),     32'h9);

        // Timeout: runway 0 occupied exactly 8 cycles
        rst[1] = 1'b1; tick(); rst[1] = 1'b0;
        req_valid[1] = 1'b1; req_id[1] = 4'h1; req_emg[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0; req_emg[1] = 1'b0;
        n = 0;
        while (runway_active[1][0] && n < 20) begin
            n++;
            tick();
        end
        chk("B.occupied_cycles", 32'(n), 32'd8);
        chk("B.timeout_mask",    32'(timeout_mask[1]), 32'h1);
        tick();
        chk("B.timeout_pulse_end", 32'(timeout_mask[1]), 32'h0);

        // Release on the expiry edge wins over the timeout
        req_valid[1] = 1'b1; req_id[1] = 4'h1; req_emg[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0; req_emg[1] = 1'b0;
        repeat (7) tick();
        rel_valid[1] = 1'b1; rel_runway[1] = 2'd0; rel_id[1] = 4'h1;
        tick();
        rel_valid[1] = 1'b0;
        chk("B.relexp_active", 32'(runway_active[1]), 32'h0);
        chk("B.relexp_mask",   32'(timeout_mask[1]),  32'h0);
        chk("B.relexp_err",    32'(rel_error[1]),     32'h0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/runway_allocator.md
Name: runway_allocator

Overview:
- Parametrised successor to the two-runway lock/unlock manager.
- Owns NUM_RUNWAYS runways and grants each accepted request the lowest-index eligible free runway.
- Checks releases against the recorded owner ID and auto-releases a runway that stays occupied TIMEOUT cycles.
- Sits between the request-decode FSM and the reply builder; grant, error and timeout events feed the reply FIFO path.

Parameters:
- NUM_RUNWAYS, 4, number of runways (2..16).
- ID_WIDTH, 4, plane ID width in bits.
- TIMEOUT, 1024, cycles a runway may stay occupied before auto-release; 0 disables timeouts.
- RESERVE_EMERGENCY, 0, when 1 runway 0 is granted only to emergency requests.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  lock request present
- req_ready  out  1  an eligible runway is free this cycle (combinational)
- req_id  in  ID_WIDTH  requesting plane ID
- req_emergency  in  1  request is an emergency landing
- grant_valid  out  1  one-cycle grant pulse
- grant_runway  out  RID_W  granted runway index
- grant_id  out  ID_WIDTH  plane ID granted
- rel_valid  in  1  release request
- rel_runway  in  RID_W  runway to release
- rel_id  in  ID_WIDTH  releasing plane ID
- rel_error  out  1  one-cycle pulse: release rejected
- timeout_mask  out  NUM_RUNWAYS  one-cycle pulse, bit per runway auto-released
- runway_active  out  NUM_RUNWAYS  occupancy, bit i = runway i
- busy_count  out  RID_W+1  number of occupied runways

Behaviour:
- Single clock domain: all state on posedge clock, synchronous active-high reset.
- RID_W = max(1, clog2(NUM_RUNWAYS)); counter width CW = clog2(TIMEOUT+1).
- Reset values:
  - runway_active, owner IDs, counters: 0.
  - grant_valid, rel_error, timeout_mask, busy_count: 0.
  - grant_runway, grant_id: 0.
- Eligibility:
  - Runway i is eligible when it is free, and not (RESERVE_EMERGENCY=1 and i=0 and req_emergency=0).
  - req_ready = OR of eligible runways, computed from current (pre-edge) state.
- Accept:
  - A request is accepted on an edge where req_valid&&req_ready.
  - The lowest eligible index k is chosen: runway_active[k]<=1, owner[k]<=req_id, counter[k]<=0.
  - Next cycle: grant_valid=1, grant_runway=k, grant_id=req_id. Latency 1 cycle.
- No free runway:
  - req_ready=0; the requester holds req_valid, and no grant or error is produced.
  - The caller decides hold versus divert.
- Release, on an edge with rel_valid:
  - rel_runway>=NUM_RUNWAYS, runway free, or owner!=rel_id: no state change, rel_error=1 next cycle.
  - Otherwise runway_active[rel_runway]<=0.
- Timeout, when TIMEOUT>0:
  - An occupied runway's counter increments every cycle.
  - On the edge where the counter equals TIMEOUT-1, the runway clears and timeout_mask[i]=1 next cycle.
  - A runway is therefore occupied for exactly TIMEOUT cycles.
  - Several runways may time out on the same edge; all their mask bits are set.
- Simultaneous events on one edge:
  - Valid release and timeout on the same runway: release wins, no timeout bit.
  - Release/timeout plus request: the freed runway is not eligible until the next cycle, because req_ready uses pre-edge state.
  - Grant and release target different runways by construction; both take effect.
- Outputs:
  - busy_count is registered and always equals the popcount of runway_active.
  - grant_runway and grant_id hold their last value when grant_valid=0.
- Reset mid-operation: all runways free next cycle, and no pending pulse survives.

Decomposition:
- Shared package (atc_pkg):
  - plane_id_t (ID_WIDTH-wide ID).
  - Runway record struct {active, owner, count}.
  - Reply opcode constants (CLEAR=3'b011, HOLD=3'b100, DIVERT=3'b110) used by the reply builder for grant/error/timeout.
- Sub-module runway_slot:
  - One runway's active/owner/counter.
  - Inputs: lock, release-match and timeout logic.
  - Instantiated NUM_RUNWAYS times by a generate loop.
- Top: priority encoder for lowest eligible index, popcount, and output pulse registers.

Test Plan:
- Reset, then req_id=4'h3 for 1 cycle (NUM_RUNWAYS=4) -> grant_valid next cycle, grant_runway=0, grant_id=3, runway_active=4'b0001, busy_count=1.
- Fill with IDs 1,2,3,4, then a 5th request (ID 5) -> req_ready=0 and no grant. Release runway 2 with ID 3 -> runway 2 freed next cycle; the held ID 5 request is granted runway 2 one cycle later.
- Release runway 1 with wrong ID 4'hA, and release a free runway -> rel_error pulses for 1 cycle each; runway_active unchanged.
- TIMEOUT=8, grant runway 0, no release -> runway_active[0] high for exactly 8 cycles, then timeout_mask=4'b0001 for 1 cycle. Repeat with a valid release on the expiry edge -> no timeout bit.
- RESERVE_EMERGENCY=1, normal requests ID 1..4 -> grants on runways 1,2,3, then req_ready=0. Emergency request ID 9 -> grant_runway=0.
- Assert reset while 3 runways are busy and a grant is pending -> next cycle all outputs 0; a subsequent request gets runway 0.
